tick_divider_bank: RTL and testbench

Parametrised bank of independent clock-enable generators: the successor to the single fixed-ratio divider. Each of CHANNELS channels has a runtime-loadable divisor, an enable, periodic or one-shot mode, a one-cycle `tick` strobe and a 50 %-duty `square` output. The block sits beside the system clock and drives slow-rate logic such as display multiplexing, debouncers and LED blink. Only the single `clk` domain is used, and it produces no derived clocks.

---
 rtl/tick_divider_bank.sv | 98 +++++++++
 tb/tb_tick_divider_bank.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_divider_bank.sv
// Bank of independent clock-enable generators. Each channel has a runtime-loadable
// divisor, periodic or one-shot counting, a one-cycle tick strobe and a square output.
module tick_divider_bank #(
    parameter int               WIDTH       = 31,
    parameter int               CHANNELS    = 4,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(250000),
    parameter int               CHW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] enable,
    input  logic [CHANNELS-1:0] mode,
    input  logic                load,
    input  logic [CHW-1:0]      load_ch,
    input  logic [WIDTH-1:0]    load_val,
    output logic                load_ack,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] square,
    output logic [CHANNELS-1:0] busy
);

    logic [WIDTH-1:0]    cnt     [CHANNELS];
    logic [WIDTH-1:0]    div     [CHANNELS];
    logic [WIDTH-1:0]    cnt_nxt [CHANNELS];
    logic [WIDTH-1:0]    div_nxt [CHANNELS];
    logic [CHANNELS-1:0] done;
    logic [CHANNELS-1:0] done_nxt;
    logic [CHANNELS-1:0] tick_nxt;
    logic [CHANNELS-1:0] square_nxt;
    logic [CHANNELS-1:0] busy_nxt;
    logic [CHANNELS-1:0] load_hit;

    // Decoding per channel means an out-of-range load_ch simply matches nothing.
    always_comb begin
        load_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            load_hit[i] = load && (load_ch == CHW'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            // NOTE: every combinational output gets a default before any branch,
            // so no path leaves it unassigned and no latch is inferred.
            div_nxt[i]    = load_hit[i] ? load_val : div[i];
            cnt_nxt[i]    = '0;
            tick_nxt[i]   = 1'b0;
            square_nxt[i] = square[i];
            done_nxt[i]   = done[i];

            if (!enable[i]) begin
                square_nxt[i] = 1'b0;
                done_nxt[i]   = 1'b0;
            end else if (load_hit[i]) begin
                done_nxt[i] = 1'b0;
            end else if (!(mode[i] && done[i])) begin
                if (cnt[i] == div[i]) begin
                    tick_nxt[i]   = 1'b1;
                    square_nxt[i] = ~square[i];
                    done_nxt[i]   = mode[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + WIDTH'(1);
                end
            end

            busy_nxt[i] = enable[i] & ~(mode[i] & done_nxt[i]);
        end
    end

    // NOTE: the divisor bank is plain flops, not a RAM, so it is reset with the
    // rest of the state; a reset must discard every loaded divisor.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
                div[i] <= DEFAULT_DIV;
            end
            done     <= '0;
            tick     <= '0;
            square   <= '0;
            busy     <= '0;
            load_ack <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees the pre-edge
            // values, independent of statement order.
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= cnt_nxt[i];
                div[i] <= div_nxt[i];
            end
            done     <= done_nxt;
            tick     <= tick_nxt;
            square   <= square_nxt;
            busy     <= busy_nxt;
            load_ack <= |load_hit;
        end
    end

endmodule

// File: tb/tb_tick_divider_bank.sv
// Self-checking bench for tick_divider_bank: directed scenarios plus randomized
// traffic against a cycle-age reference model, and a narrow 4-bit instance.
module tb_tick_divider_bank;

    localparam int W    = 31;
    localparam int CH   = 4;
    localparam int DEF  = 250000;
    localparam int SW   = 4;
    localparam int SCH  = 3;
    localparam int SDEF = 15;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [CH-1:0] enable = '0;
    logic [CH-1:0] mode = '0;
    logic          load = 1'b0;
    logic [1:0]    load_ch = '0;
    logic [W-1:0]  load_val = '0;
    logic          load_ack;
    logic [CH-1:0] tick, square, busy;

    logic [SCH-1:0] s_enable = '0;
    logic [SCH-1:0] s_mode = '0;
    logic           s_load = 1'b0;
    logic [1:0]     s_load_ch = '0;
    logic [SW-1:0]  s_load_val = '0;
    logic           s_load_ack;
    logic [SCH-1:0] s_tick, s_square, s_busy;

    tick_divider_bank #(.WIDTH(W), .CHANNELS(CH), .DEFAULT_DIV(W'(DEF))) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .load(load),
        .load_ch(load_ch), .load_val(load_val), .load_ack(load_ack),
        .tick(tick), .square(square), .busy(busy)
    );

    tick_divider_bank #(.WIDTH(SW), .CHANNELS(SCH), .DEFAULT_DIV(SW'(SDEF))) dut_s (
        .clk(clk), .reset(reset), .enable(s_enable), .mode(s_mode), .load(s_load),
        .load_ch(s_load_ch), .load_val(s_load_val), .load_ack(s_load_ack),
        .tick(s_tick), .square(s_square), .busy(s_busy)
    );

    int n_checks = 0;
    int n_pass = 0;

    // Reference model: each running channel has an age (edges since it started
    // counting); it ticks whenever age mod (div+1) == div, one-shot only once.
    longint        m_div [CH];
    longint        m_age [CH];
    logic [CH-1:0] m_fired, m_tick, m_sq, m_busy;
    logic          m_ack;

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_div[i] = DEF;
            m_age[i] = 0;
        end
        m_fired = '0; m_tick = '0; m_sq = '0; m_busy = '0; m_ack = 1'b0;
    endtask

    task automatic model_edge();
        m_ack = load;
        for (int i = 0; i < CH; i++) begin
            bit hit;
            hit = load && (int'(load_ch) == i);
            if (hit) m_div[i] = longint'(load_val);
            if (!enable[i]) begin
                m_age[i] = 0; m_tick[i] = 1'b0; m_sq[i] = 1'b0; m_fired[i] = 1'b0;
            end else if (hit) begin
                m_age[i] = 0; m_tick[i] = 1'b0; m_fired[i] = 1'b0;
            end else if (mode[i] && m_fired[i]) begin
                m_tick[i] = 1'b0;
            end else begin
                m_tick[i] = ((m_age[i] % (m_div[i] + 1)) == m_div[i]);
                if (m_tick[i]) begin
                    m_sq[i] = ~m_sq[i];
                    if (mode[i]) m_fired[i] = 1'b1;
                end
                m_age[i]++;
            end
            m_busy[i] = enable[i] && !(mode[i] && m_fired[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({load_ack, tick, square, busy} !== '0)
            $display("FAIL reset_main: got %b want 0", {load_ack, tick, square, busy});
        else n_pass++;
        n_checks++;
        if ({s_load_ack, s_tick, s_square, s_busy} !== '0)
            $display("FAIL reset_small: got %b want 0", {s_load_ack, s_tick, s_square, s_busy});
        else n_pass++;
        reset = 1'b1;
        step();
    endtask

    task automatic test_periodic();
        int ticks = 0;
        load = 1'b1; load_ch = 2'd0; load_val = W'(3);
        step();
        load = 1'b0;
        n_checks++;
        if (load_ack !== 1'b1) $display("FAIL periodic_ack: got %b want 1", load_ack);
        else n_pass++;
        enable[0] = 1'b1;
        for (int k = 0; k < 24; k++) begin
            step();
            n_checks++;
            if ({tick, square, busy, load_ack} !== {m_tick, m_sq, m_busy, m_ack})
                $display("FAIL periodic_model k=%0d: got %b want %b", k,
                         {tick, square, busy, load_ack}, {m_tick, m_sq, m_busy, m_ack});
            else n_pass++;
            n_checks++;
            if ({tick[0], square[0]} !== {1'(k % 4 == 3), 1'(((k + 1) / 4) % 2)})
                $display("FAIL periodic_ch0 k=%0d: got tick=%b sq=%b want tick=%b sq=%b", k,
                         tick[0], square[0], 1'(k % 4 == 3), 1'(((k + 1) / 4) % 2));
            else n_pass++;
            n_checks++;
            if ({tick[3:1], square[3:1], busy[3:1]} !== '0)
                $display("FAIL periodic_idle k=%0d: got %b want 0", k,
                         {tick[3:1], square[3:1], busy[3:1]});
            else n_pass++;
            ticks += int'(tick[0]);
        end
        n_checks++;
        if (ticks != 6) $display("FAIL periodic_count: got %0d want 6", ticks);
        else n_pass++;
        enable[0] = 1'b0;
        step();
    endtask

    task automatic test_oneshot();
        int ticks = 0;
        int first = -1;
        load = 1'b1; load_ch = 2'd1; load_val = W'(5);
        step();
        load = 1'b0;
        mode[1] = 1'b1; enable[1] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            n_checks++;
            if ({tick, square, busy, load_ack} !== {m_tick, m_sq, m_busy, m_ack})
                $display("FAIL oneshot_model k=%0d: got %b want %b", k,
                         {tick, square, busy, load_ack}, {m_tick, m_sq, m_busy, m_ack});
            else n_pass++;
            if (tick[1]) begin
                ticks++;
                if (first < 0) first = k;
            end
        end
        n_checks++;
        if (ticks != 1 || first != 5)
            $display("FAIL oneshot_first: got ticks=%0d at=%0d want ticks=1 at=5", ticks, first);
        else n_pass++;
        n_checks++;
        if (busy[1] !== 1'b0) $display("FAIL oneshot_busy: got %b want 0", busy[1]);
        else n_pass++;
        enable[1] = 1'b0;
        step();
        enable[1] = 1'b1;
        ticks = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            n_checks++;
            if ({tick, square, busy} !== {m_tick, m_sq, m_busy})
                $display("FAIL oneshot_rearm k=%0d: got %b want %b", k,
                         {tick, square, busy}, {m_tick, m_sq, m_busy});
            else n_pass++;
            ticks += int'(tick[1]);
        end
        n_checks++;
        if (ticks != 1) $display("FAIL oneshot_second: got %0d ticks want 1", ticks);
        else n_pass++;
        enable[1] = 1'b0; mode[1] = 1'b0;
        step();
    endtask

    task automatic test_div_zero();
        load = 1'b1; load_ch = 2'd2; load_val = W'(0);
        step();
        load = 1'b0;
        enable[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            n_checks++;
            if ({tick[2], square[2]} !== {1'b1, 1'(k % 2 == 0)})
                $display("FAIL divzero k=%0d: got tick=%b sq=%b want tick=1 sq=%b", k,
                         tick[2], square[2], 1'(k % 2 == 0));
            else n_pass++;
        end
        enable[2] = 1'b0;
        step();
        n_checks++;
        if ({tick[2], square[2], busy[2]} !== 3'b000)
            $display("FAIL divzero_disable: got %b want 000", {tick[2], square[2], busy[2]});
        else n_pass++;
    endtask

    task automatic test_load_terminal();
        int ticks = 0;
        load = 1'b1; load_ch = 2'd3; load_val = W'(7);
        step();
        load = 1'b0;
        enable[3] = 1'b1;
        repeat (7) step();
        load = 1'b1; load_ch = 2'd3; load_val = W'(2);
        step();
        load = 1'b0;
        n_checks++;
        if ({tick[3], load_ack} !== 2'b01)
            $display("FAIL term_load: got tick=%b ack=%b want tick=0 ack=1", tick[3], load_ack);
        else n_pass++;
        for (int k = 0; k < 9; k++) begin
            step();
            n_checks++;
            if ({tick, square, busy, load_ack} !== {m_tick, m_sq, m_busy, m_ack})
                $display("FAIL term_model k=%0d: got %b want %b", k,
                         {tick, square, busy, load_ack}, {m_tick, m_sq, m_busy, m_ack});
            else n_pass++;
            ticks += int'(tick[3]);
        end
        n_checks++;
        if (ticks != 3) $display("FAIL term_count: got %0d want 3", ticks);
        else n_pass++;
        enable[3] = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            load = ($urandom_range(0, 7) == 0);
            load_ch = 2'($urandom_range(0, 3));
            load_val = W'($urandom_range(0, 9));
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 15) == 0) begin
                    if (enable[i]) enable[i] = 1'b0;
                    else begin
                        mode[i] = 1'($urandom_range(0, 1));
                        enable[i] = 1'b1;
                    end
                end
            end
            step();
            n_checks++;
            if ({tick, square, busy, load_ack} !== {m_tick, m_sq, m_busy, m_ack})
                $display("FAIL random cyc=%0d: got %b want %b", cyc,
                         {tick, square, busy, load_ack}, {m_tick, m_sq, m_busy, m_ack});
            else n_pass++;
        end
        load = 1'b0; enable = '0; mode = '0;
        step();
    endtask

    task automatic test_reset_midcount();
        int ticks = 0;
        load = 1'b1; load_ch = 2'd0; load_val = W'(3);
        s_load = 1'b1; s_load_ch = 2'd0; s_load_val = SW'(2);
        step();
        load = 1'b0; s_load = 1'b0;
        enable = 4'b1111; s_enable[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            ticks += int'(s_tick[0]);
        end
        n_checks++;
        if (ticks != 2) $display("FAIL small_loaded: got %0d ticks want 2", ticks);
        else n_pass++;
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        n_checks++;
        if ({load_ack, tick, square, busy} !== '0)
            $display("FAIL midreset_main: got %b want 0", {load_ack, tick, square, busy});
        else n_pass++;
        n_checks++;
        if ({s_load_ack, s_tick, s_square, s_busy} !== '0)
            $display("FAIL midreset_small: got %b want 0", {s_load_ack, s_tick, s_square, s_busy});
        else n_pass++;
        model_reset();
        enable = '0; s_enable = '0;
        @(posedge clk);
        #1 reset = 1'b1;
        enable[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            n_checks++;
            if ({tick, square, busy} !== {m_tick, m_sq, m_busy})
                $display("FAIL midreset_default k=%0d: got %b want %b", k,
                         {tick, square, busy}, {m_tick, m_sq, m_busy});
            else n_pass++;
        end
        enable = '0;
        step();
    endtask

    task automatic test_small_width();
        int ticks = 0;
        s_enable[0] = 1'b1;
        for (int k = 0; k < 48; k++) begin
            if (k == 10) begin
                s_load = 1'b1; s_load_ch = 2'd3; s_load_val = SW'(2);
            end
            step();
            s_load = 1'b0;
            if (k == 10) begin
                n_checks++;
                if (s_load_ack !== 1'b0) $display("FAIL invalid_load_ack: got %b want 0", s_load_ack);
                else n_pass++;
            end
            n_checks++;
            if ({s_tick, s_square, s_busy} !==
                {2'b00, 1'(k % 16 == 15), 2'b00, 1'(((k + 1) / 16) % 2), 3'b001})
                $display("FAIL small_wrap k=%0d: got %b want %b", k, {s_tick, s_square, s_busy},
                         {2'b00, 1'(k % 16 == 15), 2'b00, 1'(((k + 1) / 16) % 2), 3'b001});
            else n_pass++;
            ticks += int'(s_tick[0]);
        end
        n_checks++;
        if (ticks != 3) $display("FAIL small_count: got %0d want 3", ticks);
        else n_pass++;
        s_enable = '0;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_div_zero();
        test_load_terminal();
        test_random();
        test_reset_midcount();
        test_small_width();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
